alu_fpga_seq: RTL and testbench



---
 rtl/alu_fpga_seq.sv | 204 ++++++++++++++++++++
 tb/tb_alu_fpga_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_fpga_seq.sv
// Key-sequenced ALU bring-up: debounced KEYs load A, B, opcode; result and flags shown on paged HEX/LEDG.
// Latency: raw press to pulse 2+DEBOUNCE_CYC cycles; register/state update on pulse+1, result on pulse+2.
// Backpressure: none, operator paced. ALU_FPGA_HISTORY_EN adds a 4-deep result history viewed with KEY[3].
module alu_fpga_seq #(
    parameter int DATA_W       = 32,
    parameter int SW_W         = 17,
    parameter int NDIGITS      = 8,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [3:0]             KEY,
    input  logic [SW_W-1:0]        SW,
    output logic [DATA_W-1:0]      port_a,
    output logic [DATA_W-1:0]      port_b,
    output logic [3:0]             aluop,
    input  logic [DATA_W-1:0]      port_out,
    input  logic                   negative,
    input  logic                   overflow,
    input  logic                   zero,
    output logic [7*NDIGITS-1:0]   hex,
    output logic [7:0]             ledg
);

    localparam int NPAGES = (DATA_W + 4*NDIGITS - 1) / (4*NDIGITS);
    localparam int PG_W   = (NPAGES > 1) ? $clog2(NPAGES) : 1;
    localparam int NNIB   = DATA_W / 4;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_SHOW = 3'd4;

    logic [3:0]            sync1, sync2, stable, armed, press;
    logic [1:0]            warm;
    logic [3:0][CNT_W-1:0] cnt;

    logic [2:0]        state, state_n;
    logic [PG_W-1:0]   page;
    logic [DATA_W-1:0] result, disp_val, src, sw_ext;
    logic [2:0]        flags, disp_flg;
    logic              commit, back, page_p, hist_p;

    assign sw_ext = DATA_W'(SW);

    // A key only becomes armed once it has been seen released after reset,
    // so a button held through reset release never produces a press.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1  <= '1;
            sync2  <= '1;
            warm   <= '0;
            stable <= '1;
            armed  <= '0;
            press  <= '0;
            cnt    <= '0;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
            warm  <= {warm[0], 1'b1};
            for (int k = 0; k < 4; k++) begin
                press[k] <= 1'b0;
                if (warm[1] && sync2[k])
                    armed[k] <= 1'b1;
                if (sync2[k] == stable[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_MAX) begin
                    cnt[k]    <= '0;
                    stable[k] <= sync2[k];
                    press[k]  <= ~sync2[k] & armed[k];
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    assign commit = press[0];
    assign back   = press[1] & ~press[0];
    assign page_p = press[2] & ~|press[1:0];
    assign hist_p = press[3] & ~|press[2:0];

    always_comb begin
        state_n = state;
        case (state)
            S_A:     if (commit) state_n = S_B;
            S_B:     if (commit) state_n = S_OP;  else if (back) state_n = S_A;
            S_OP:    if (commit) state_n = S_EXEC; else if (back) state_n = S_B;
            S_EXEC:  state_n = S_SHOW;
            S_SHOW:  if (commit) state_n = S_A;   else if (back) state_n = S_OP;
            default: state_n = S_A;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= S_A;
            port_a <= '0;
            port_b <= '0;
            aluop  <= '0;
            result <= '0;
            flags  <= '0;
            page   <= '0;
        end else begin
            state <= state_n;
            if (state == S_A  && commit) port_a <= sw_ext;
            if (state == S_B  && commit) port_b <= sw_ext;
            if (state == S_OP && commit) aluop  <= SW[3:0];
            if (state == S_EXEC) begin
                result <= port_out;
                flags  <= {overflow, negative, zero};
            end
            if (state_n != state)
                page <= '0;
            else if (page_p)
                page <= (page == PG_W'(NPAGES - 1)) ? '0 : page + 1'b1;
        end
    end

`ifdef ALU_FPGA_HISTORY_EN
    logic [3:0][DATA_W-1:0] h_res;
    logic [3:0][2:0]        h_flg;
    logic [1:0]             h_wr, h_k, h_rd;
    logic [2:0]             h_cnt;

    // Entry k counts back from the most recent write; k=0 is the latest result.
    assign h_rd = h_wr - 2'd1 - h_k;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            h_res <= '0;
            h_flg <= '0;
            h_wr  <= '0;
            h_k   <= '0;
            h_cnt <= '0;
        end else begin
            if (state == S_EXEC) begin
                h_res[h_wr] <= port_out;
                h_flg[h_wr] <= {overflow, negative, zero};
                h_wr        <= h_wr + 2'd1;
                if (h_cnt != 3'd4)
                    h_cnt <= h_cnt + 3'd1;
            end
            if (state_n == S_SHOW && state != S_SHOW)
                h_k <= '0;
            else if (state == S_SHOW && hist_p)
                h_k <= (({1'b0, h_k} + 3'd1) >= h_cnt) ? 2'd0 : h_k + 2'd1;
        end
    end
`else
    logic unused_hist;
    assign unused_hist = hist_p;
`endif

    always_comb begin
        disp_val = result;
        disp_flg = flags;
`ifdef ALU_FPGA_HISTORY_EN
        if (state == S_SHOW) begin
            disp_val = h_res[h_rd];
            disp_flg = h_flg[h_rd];
        end
`endif
    end

    assign src = (state == S_EXEC || state == S_SHOW) ? disp_val : sw_ext;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b0100111;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Nibbles past the top of the data word are blanked on the last page.
    always_comb begin
        hex = '1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (int'(page) * NDIGITS + i < NNIB)
                hex[7*i +: 7] = seg7(4'(src >> (4 * (int'(page) * NDIGITS + i))));
        end
    end

    assign ledg = {disp_flg, state == S_SHOW, state == S_EXEC, state == S_OP,
                   state == S_B, state == S_A};

endmodule

// File: tb/tb_alu_fpga_seq.sv
// Bench for alu_fpga_seq: abstract operator-level model checked every cycle, plus literal spot checks.
module tb_alu_fpga_seq;
    localparam int DW = 32, SWW = 17, ND = 4, DC = 4, NP = 2;
    localparam int S_A = 0, S_B = 1, S_OP = 2, S_EXEC = 3, S_SHOW = 4;
`ifdef ALU_FPGA_HISTORY_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic [3:0]      KEY = 4'hF;
    logic [SWW-1:0]  SW = 17'h0_0012;
    logic [DW-1:0]   port_a, port_b, port_out;
    logic [3:0]      aluop;
    logic            negative, overflow, zero;
    logic [7*ND-1:0] hex;
    logic [7:0]      ledg;

    int total = 0, bad = 0;
    int cyc = 0;
    int pend_at = -1;
    logic [3:0] pend_mask = 4'h0;

    int          m_state = 0, m_page = 0, m_k = 0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic [3:0]  m_op = '0;
    logic [2:0]  m_flg = '0;
    logic [34:0] m_hist[$];

    always #5 CLK = ~CLK;

    function automatic logic [34:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] o;
        logic ov;
        ov = 1'b0;
        case (op)
            4'h0: o = 32'h0;
            4'h1: o = a - b;
            4'h2: o = a & b;
            4'h3: begin o = a + b; ov = (a[31] == b[31]) && (o[31] != a[31]); end
            default: o = a ^ b;
        endcase
        return {ov, o[31], o == 32'h0, o};
    endfunction

    assign {overflow, negative, zero, port_out} = alu(port_a, port_b, aluop);

    alu_fpga_seq #(.DATA_W(DW), .SW_W(SWW), .NDIGITS(ND), .DEBOUNCE_CYC(DC)) dut (
        .CLK(CLK), .nRST(nRST), .KEY(KEY), .SW(SW),
        .port_a(port_a), .port_b(port_b), .aluop(aluop), .port_out(port_out),
        .negative(negative), .overflow(overflow), .zero(zero),
        .hex(hex), .ledg(ledg)
    );

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b0100111;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] exp_hex(input logic [31:0] v, input int pg);
        logic [27:0] h;
        for (int d = 0; d < ND; d++) begin
            int n;
            n = pg * ND + d;
            if (n >= DW / 4) h[7*d +: 7] = 7'h7F;
            else             h[7*d +: 7] = seg(4'((v >> (4 * n)) & 32'hF));
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Operator-level model: one key action per debounced press, priority to the lowest key index.
    always @(posedge CLK or negedge nRST) begin : model
        int act;
        int nxt;
        logic [34:0] r;
        if (!nRST) begin
            m_state = S_A; m_page = 0; m_k = 0;
            m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_flg = '0;
            m_hist.delete();
        end else begin
            act = -1;
            if (pend_at == cyc)
                for (int i = 3; i >= 0; i--) if (pend_mask[i]) act = i;
            if (m_state == S_EXEC) begin
                r = alu(m_a, m_b, m_op);
                m_res = r[31:0];
                m_flg = r[34:32];
                m_hist.push_front(r);
                if (m_hist.size() > 4) void'(m_hist.pop_back());
                m_state = S_SHOW; m_page = 0; m_k = 0;
            end else begin
                nxt = m_state;
                case (act)
                    0: case (m_state)
                           S_A:  begin m_a = 32'(SW); nxt = S_B; end
                           S_B:  begin m_b = 32'(SW); nxt = S_OP; end
                           S_OP: begin m_op = SW[3:0]; nxt = S_EXEC; end
                           S_SHOW: nxt = S_A;
                           default: ;
                       endcase
                    1: case (m_state)
                           S_B: nxt = S_A;
                           S_OP: nxt = S_B;
                           S_SHOW: nxt = S_OP;
                           default: ;
                       endcase
                    2: m_page = (m_page + 1) % NP;
                    3: if (HIST && m_state == S_SHOW && m_hist.size() > 0)
                           m_k = (m_k + 1) % m_hist.size();
                    default: ;
                endcase
                if (nxt != m_state) begin m_state = nxt; m_page = 0; end
            end
        end
    end

    always @(negedge CLK) begin : compare
        logic [31:0] v;
        logic [2:0] f;
        logic [4:0] oh;
        if (nRST) begin
            v = (m_state < S_EXEC) ? 32'(SW) : m_res;
            f = m_flg;
            if (HIST && m_state == S_SHOW && m_hist.size() > 0) begin
                v = m_hist[m_k][31:0];
                f = m_hist[m_k][34:32];
            end
            oh = '0;
            oh[m_state] = 1'b1;
            chk("ledg", 64'(ledg), 64'({f, oh}));
            chk("hex", 64'(hex), 64'(exp_hex(v, m_page)));
            chk("port_a", 64'(port_a), 64'(m_a));
            chk("port_b", 64'(port_b), 64'(m_b));
            chk("aluop", 64'(aluop), 64'(m_op));
        end
    end

    task automatic press_hold(input logic [3:0] mask, input int hold);
        @(posedge CLK); #1;
        KEY = ~mask;
        if (hold >= DC) begin pend_at = cyc + 2 + DC; pend_mask = mask; end
        repeat (hold) @(posedge CLK);
        #1 KEY = 4'hF;
    endtask

    task automatic settle();
        repeat (2 * DC + 10) @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [3:0] mask, input logic [SWW-1:0] sw);
        @(posedge CLK); #1 SW = sw;
        press_hold(mask, DC);
        settle();
    endtask

    task automatic do_reset();
        @(posedge CLK); #1 nRST = 1'b0;
        pend_at = -1;
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
    endtask

    task automatic wait_exec();
        for (int i = 0; i < 40 && cyc != pend_at + 1; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int r;
        logic [3:0] m;
        #1;
        chk("rst_ledg", 64'(ledg), 64'h01);
        chk("rst_hex", 64'(hex), 64'({7'b1000000, 7'b1000000, 7'b1111001, 7'b0100100}));
        chk("rst_ports", 64'({port_a, aluop}), 64'h0);
        chk("rst_port_b", 64'(port_b), 64'h0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        repeat (6) @(posedge CLK);

        press(4'h1, 17'h1_2345);
        press(4'h1, 17'h0_0001);
        @(posedge CLK); #1 SW = 17'h0_0003;
        press_hold(4'h1, DC);
        wait_exec();
        chk("exec_at_p1", 64'(ledg[4:0]), 64'h08);
        chk("ops_at_p1", 64'({port_a, aluop}), 64'({32'h12345, 4'h3}));
        @(posedge CLK); #1;
        chk("show_at_p2", 64'(ledg[4:0]), 64'h10);
        chk("res_pg0", 64'(hex), 64'({7'b0100100, 7'b0110000, 7'b0011001, 7'b0000010}));
        settle();
        press(4'h4, SW);
        chk("res_pg1", 64'(hex), 64'({7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001}));
        press(4'h4, SW);
        chk("res_pg_wrap", 64'(hex), 64'({7'b0100100, 7'b0110000, 7'b0011001, 7'b0000010}));

        press(4'h2, SW);
        chk("back_to_op", 64'(ledg[4:0]), 64'h04);
        press(4'h1, 17'h0_0000);
        chk("zero_ledg", 64'(ledg), 64'h30);
        chk("zero_keep_a", 64'(port_a), 64'h12345);
        chk("zero_keep_b", 64'(port_b), 64'h1);

        press(4'h1, SW);
        press(4'h1, 17'h0_0005);
        press(4'h3, 17'h0_0007);
        chk("commit_beats_back", 64'(ledg[4:0]), 64'h04);
        @(posedge CLK); #1 SW = 17'h0_0003;
        press_hold(4'h1, DC);
        wait_exec();
        chk("pre_rst_exec", 64'(ledg[4:0]), 64'h08);
        nRST = 1'b0;
        pend_at = -1;
        #1;
        chk("rst_exec_ledg", 64'(ledg), 64'h01);
        chk("rst_exec_a", 64'(port_a), 64'h0);
        @(posedge CLK); #1 nRST = 1'b1;
        repeat (6) @(posedge CLK);

        KEY = 4'hE;
        do_reset();
        repeat (20) @(posedge CLK);
        #1 KEY = 4'hF;
        settle();
        chk("held_thru_rst", 64'(ledg), 64'h01);

        press_hold(4'h1, 3);
        settle();
        chk("glitch", 64'(ledg), 64'h01);
        @(posedge CLK); #1 SW = 17'h0_00AB;
        press_hold(4'h1, 100);
        settle();
        chk("long_hold", 64'(ledg), 64'h02);
        chk("long_hold_a", 64'(port_a), 64'hAB);

        do_reset();
        for (int s = 1; s <= 3; s++) begin
            press(4'h1, 17'h0);
            press(4'h1, 17'(s));
            press(4'h1, 17'h3);
            if (s < 3) press(4'h1, SW);
        end
        chk("hist_latest", 64'(hex[6:0]), 64'(7'b0110000));
        press(4'h8, SW);
        chk("hist_1", 64'(hex[6:0]), HIST ? 64'(7'b0100100) : 64'(7'b0110000));
        press(4'h8, SW);
        chk("hist_2", 64'(hex[6:0]), HIST ? 64'(7'b1111001) : 64'(7'b0110000));
        press(4'h8, SW);
        chk("hist_3", 64'(hex[6:0]), 64'(7'b0110000));

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            m = (r < 5) ? 4'h1 : (r < 7) ? 4'h2 : (r < 9) ? 4'h4 : 4'h8;
            if ($urandom_range(0, 7) == 0) m = m | (4'h1 << $urandom_range(0, 3));
            @(posedge CLK); #1 SW = 17'($urandom);
            press_hold(m, DC + $urandom_range(0, 5));
            settle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
